// File: rtl/dphy_rx_aligner.sv
// D-PHY HS receive byte aligner.
// Hunts for the HS leader sync byte in a sliding 16-bit window built from
// the current and previous deserialized words, locks the bit offset where it
// was found, and then re-frames every following word at that offset until
// the lane leaves HS mode.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | lane not in HS mode, waiting for enable_i
// ST_HUNT     | searching each window for the sync byte, counting words
// ST_DATA     | locked; emitting one aligned byte per word clock
// ST_WAIT_LOW | sync not found in time; ignore the burst until enable_i drops
module dphy_rx_aligner #(
  parameter logic [7:0]  g_sync_pattern = 8'hB8,
  parameter int unsigned g_sync_timeout = 16
) (
  input  logic       clk_word_i,
  input  logic       rst_n_a_i,
  input  logic       enable_i,
  input  logic [7:0] d_i,
  output logic [7:0] q_o,
  output logic       valid_o,
  output logic       sync_o,
  output logic [2:0] offset_o,
  output logic       active_o,
  output logic       err_sot_o,
  output logic       eot_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HUNT     = 2'd1,
    ST_DATA     = 2'd2,
    ST_WAIT_LOW = 2'd3
  } state_t;

  // The timeout is limited to 255, so an 8-bit hunt counter always suffices.
  localparam int unsigned HUNT_W = 8;
  localparam logic [HUNT_W-1:0] HUNT_LAST = HUNT_W'(g_sync_timeout - 1);

  state_t            state_q;
  state_t            state_d;
  logic [7:0]        prev_q;
  logic [15:0]       win;
  logic [HUNT_W-1:0] hunt_cnt;
  logic [2:0]        off_q;

  logic              match;
  logic [2:0]        match_k;
  logic              timeout_hit;

  logic              hunt_clr;
  logic              hunt_inc;
  logic              sync_set;
  logic              err_set;
  logic              eot_set;
  logic              load_byte;

  // The older word sits in the low half so bit 0 of the window is the
  // earliest bit on the wire.
  assign win         = {d_i, prev_q};
  assign timeout_hit = (hunt_cnt == HUNT_LAST);
  assign active_o    = (state_q == ST_DATA);
  assign offset_o    = off_q;

  // Sync search over all eight bit offsets; scanning downwards lets the
  // lowest matching offset overwrite any higher one.
  always_comb begin
    match   = 1'b0;
    match_k = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (win[k +: 8] == g_sync_pattern) begin
        match   = 1'b1;
        match_k = 3'(k);
      end
    end
  end

  // State register.
  always_ff @(posedge clk_word_i or negedge rst_n_a_i) begin
    if (!rst_n_a_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; losing enable_i always wins, and a match beats the
  // timeout when both land on the same word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_HUNT;
      end
      ST_HUNT: begin
        if (!enable_i)        state_d = ST_IDLE;
        else if (match)       state_d = ST_DATA;
        else if (timeout_hit) state_d = ST_WAIT_LOW;
      end
      ST_DATA: begin
        if (!enable_i) state_d = ST_IDLE;
      end
      ST_WAIT_LOW: begin
        if (!enable_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-state control strobes feeding the registered datapath and outputs.
  always_comb begin
    hunt_clr  = 1'b0;
    hunt_inc  = 1'b0;
    sync_set  = 1'b0;
    err_set   = 1'b0;
    eot_set   = 1'b0;
    load_byte = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hunt_clr = enable_i;
      end
      ST_HUNT: begin
        if (enable_i) begin
          if (match) begin
            sync_set = 1'b1;
          end else if (timeout_hit) begin
            err_set = 1'b1;
          end else begin
            hunt_inc = 1'b1;
          end
        end
      end
      ST_DATA: begin
        load_byte = enable_i;
        eot_set   = !enable_i;
      end
      default: begin
      end
    endcase
  end

  // Previous word is captured every clock, independent of state.
  always_ff @(posedge clk_word_i or negedge rst_n_a_i) begin
    if (!rst_n_a_i) begin
      prev_q <= 8'h00;
    end else begin
      prev_q <= d_i;
    end
  end

  // Hunt word counter, cleared on entry to HUNT.
  always_ff @(posedge clk_word_i or negedge rst_n_a_i) begin
    if (!rst_n_a_i) begin
      hunt_cnt <= '0;
    end else if (hunt_clr) begin
      hunt_cnt <= '0;
    end else if (hunt_inc) begin
      hunt_cnt <= hunt_cnt + 1'b1;
    end
  end

  // Offset is captured once at lock and held for the rest of the burst.
  always_ff @(posedge clk_word_i or negedge rst_n_a_i) begin
    if (!rst_n_a_i) begin
      off_q <= 3'd0;
    end else if (sync_set) begin
      off_q <= match_k;
    end
  end

  // Registered outputs; q_o only moves when a new byte is loaded.
  always_ff @(posedge clk_word_i or negedge rst_n_a_i) begin
    if (!rst_n_a_i) begin
      q_o       <= 8'h00;
      valid_o   <= 1'b0;
      sync_o    <= 1'b0;
      err_sot_o <= 1'b0;
      eot_o     <= 1'b0;
    end else begin
      valid_o   <= load_byte;
      sync_o    <= sync_set;
      err_sot_o <= err_set;
      eot_o     <= eot_set;
      if (load_byte) begin
        q_o <= win[off_q +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dphy_rx_aligner.sv
// Bench for dphy_rx_aligner: bursts are built as a bit stream (zero preamble,
// sync byte at a chosen bit position, random payload, random tail), packed
// into words, and outputs are compared with what that stream implies.
module tb_dphy_rx_aligner;

  localparam logic [7:0] SYNC    = 8'hB8;
  localparam int         TIMEOUT = 16;

  logic       clk_word_i = 1'b0;
  logic       rst_n_a_i  = 1'b0;
  logic       enable_i   = 1'b0;
  logic [7:0] d_i        = 8'h00;
  logic [7:0] q_o;
  logic       valid_o;
  logic       sync_o;
  logic [2:0] offset_o;
  logic       active_o;
  logic       err_sot_o;
  logic       eot_o;

  int n_checks = 0;
  int n_errors = 0;

  dphy_rx_aligner #(
    .g_sync_pattern(SYNC),
    .g_sync_timeout(TIMEOUT)
  ) dut (
    .clk_word_i(clk_word_i),
    .rst_n_a_i (rst_n_a_i),
    .enable_i  (enable_i),
    .d_i       (d_i),
    .q_o       (q_o),
    .valid_o   (valid_o),
    .sync_o    (sync_o),
    .offset_o  (offset_o),
    .active_o  (active_o),
    .err_sot_o (err_sot_o),
    .eot_o     (eot_o)
  );

  always #5 clk_word_i = ~clk_word_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_word_i);
    #1;
  endtask

  task automatic check_all_zero(input string when);
    check_val({when, " q_o"},       q_o, 0);
    check_val({when, " valid_o"},   valid_o, 0);
    check_val({when, " sync_o"},    sync_o, 0);
    check_val({when, " offset_o"},  offset_o, 0);
    check_val({when, " active_o"},  active_o, 0);
    check_val({when, " err_sot_o"}, err_sot_o, 0);
    check_val({when, " eot_o"},     eot_o, 0);
  endtask

  // Sync starts at stream bit p (word 0 is the one seen while leaving IDLE).
  // The window first holds the whole sync on word p/8+1; payload byte j is
  // emitted on word p/8+2+j. cut>0 stops driving after that many words,
  // leaving enable_i high.
  task automatic run_burst(input int p, input int n, input int cut);
    bit         bits[$];
    logic [7:0] pl[$];
    logic [7:0] sync_v;
    logic [7:0] b;
    logic [7:0] word;
    int         w;
    int         dw;
    int         vcnt;
    sync_v = SYNC;
    w  = p / 8 + 2 + n;
    dw = p / 8 + 1;
    for (int j = 0; j < n; j++) pl.push_back(8'($urandom));
    for (int x = 0; x < 8 * w; x++) begin
      if (x < p) begin
        bits.push_back(1'b0);
      end else if (x < p + 8) begin
        bits.push_back(sync_v[x - p]);
      end else if (x < p + 8 + 8 * n) begin
        b = pl[(x - p - 8) / 8];
        bits.push_back(b[(x - p - 8) % 8]);
      end else begin
        bits.push_back(1'($urandom));
      end
    end
    if (cut > 0 && cut < w) w = cut;
    vcnt = 0;
    for (int i = 0; i < w; i++) begin
      for (int t = 0; t < 8; t++) word[t] = bits[8 * i + t];
      d_i      = word;
      enable_i = 1'b1;
      tick();
      check_val("burst sync_o",    sync_o, i == dw);
      check_val("burst err_sot_o", err_sot_o, 0);
      check_val("burst active_o",  active_o, i >= dw);
      check_val("burst valid_o",   valid_o, i > dw);
      check_val("burst eot_o",     eot_o, 0);
      if (active_o) check_val("burst offset_o", offset_o, p % 8);
      if (valid_o && vcnt < n) begin
        check_val("burst q_o", q_o, pl[vcnt]);
        vcnt++;
      end
    end
    if (cut == 0) begin
      enable_i = 1'b0;
      d_i      = 8'h00;
      tick();
      check_val("end eot_o",         eot_o, 1);
      check_val("end valid_o",       valid_o, 0);
      check_val("end active_o",      active_o, 0);
      check_val("end payload_count", vcnt, n);
      check_val("end q_o hold",      q_o, pl[n - 1]);
      tick();
      check_val("after eot_o", eot_o, 0);
      check_val("after q_o hold", q_o, pl[n - 1]);
      tick();
    end
  endtask

  // Zero words for the whole hunt; later words carry sync bytes that must be
  // ignored while waiting for enable_i to fall.
  task automatic run_timeout();
    for (int i = 0; i < 24; i++) begin
      d_i      = (i >= 18) ? SYNC : 8'h00;
      enable_i = 1'b1;
      tick();
      check_val("timeout err_sot_o", err_sot_o, i == TIMEOUT);
      check_val("timeout sync_o",    sync_o, 0);
      check_val("timeout valid_o",   valid_o, 0);
      check_val("timeout active_o",  active_o, 0);
    end
    enable_i = 1'b0;
    d_i      = 8'h00;
    tick();
    check_val("timeout exit eot_o",     eot_o, 0);
    check_val("timeout exit err_sot_o", err_sot_o, 0);
    tick();
  endtask

  task automatic run_abort(input int m);
    for (int i = 0; i < m; i++) begin
      d_i      = 8'h00;
      enable_i = 1'b1;
      tick();
      check_val("abort sync_o",    sync_o, 0);
      check_val("abort err_sot_o", err_sot_o, 0);
      check_val("abort active_o",  active_o, 0);
    end
    enable_i = 1'b0;
    tick();
    check_val("abort exit eot_o",     eot_o, 0);
    check_val("abort exit err_sot_o", err_sot_o, 0);
    check_val("abort exit sync_o",    sync_o, 0);
    tick();
  endtask

  initial begin
    int p;
    rst_n_a_i = 1'b0;
    #12;
    check_all_zero("reset");
    rst_n_a_i = 1'b1;
    tick();
    tick();

    run_burst(19, 6, 0);
    run_burst(8, 2, 0);
    run_burst(15, 5, 0);
    run_burst(0, 3, 0);
    run_burst(127, 4, 0);
    run_burst(120, 1, 0);

    for (int r = 0; r < 12; r++) begin
      run_burst(int'($urandom_range(0, 127)), int'($urandom_range(1, 12)), 0);
    end

    run_timeout();
    run_burst(int'($urandom_range(0, 63)), 5, 0);

    run_abort(5);
    run_burst(int'($urandom_range(0, 63)), 4, 0);

    p = int'($urandom_range(0, 63));
    run_burst(p, 8, p / 8 + 4);
    #3 rst_n_a_i = 1'b0;
    #1;
    check_all_zero("mid-burst reset");
    enable_i = 1'b0;
    d_i      = 8'h00;
    tick();
    tick();
    #2 rst_n_a_i = 1'b1;
    tick();
    check_val("post reset eot_o",   eot_o, 0);
    check_val("post reset valid_o", valid_o, 0);
    tick();
    run_burst(int'($urandom_range(0, 127)), 6, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
